// File: rtl/div_arbiter.sv
// div_arbiter: shares one shift-subtract divider among N_REQ requesters.
// Round-robin grant, one division in flight, signed support via
// sign/magnitude pre/post-processing, divide-by-zero answered without the core.
//
// Handshake semantics (both directions): a transfer happens on a rising
// edge where valid and ready are both high. A requester holds req_valid and
// its operands until it sees req_ready; the block holds rsp_valid and the
// rsp_* buses stable until the owning requester's rsp_ready is high.

// div_subshift: unsigned restoring divider, one quotient bit per cycle.
// done idles high, drops the cycle after start, rises after W steps.
module div_subshift #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_r;
  logic [W-1:0]  r_d;
  logic          r_done;
  logic [W:0]    w_trial;
  logic [W:0]    w_diff;
  logic          w_ge;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    w_trial = {r_r, r_q[W-1]};
    w_diff  = w_trial - {1'b0, r_d};
    w_ge    = ~w_diff[W];
  end

  // Load on start, then shift one quotient bit in per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_d    <= '0;
      r_done <= 1'b1;
    end else if (start) begin
      r_q    <= dividend;
      r_r    <= '0;
      r_d    <= divisor;
      r_cnt  <= CW'(W);
      r_done <= 1'b0;
    end else if (r_cnt != '0) begin
      r_r   <= w_ge ? w_diff[W-1:0] : w_trial[W-1:0];
      r_q   <= {r_q[W-2:0], w_ge};
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_done <= 1'b1;
    end
  end

  assign done      = r_done;
  assign quotient  = r_q;
  assign remainder = r_r;
endmodule

module div_arbiter #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_signed,
  input  logic [N_REQ*DATA_W-1:0] req_dividend,
  input  logic [N_REQ*DATA_W-1:0] req_divisor,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_quotient,
  output logic [DATA_W-1:0]       rsp_remainder,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id,
  output logic [1:0]              dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_last;
  logic [ID_W-1:0]     r_gid;
  logic [DATA_W-1:0]   r_dvd;
  logic [DATA_W-1:0]   r_dvs;
  logic                r_sgn;
  logic                r_seen_low;
  logic [N_REQ-1:0]    r_rsp_valid;
  logic [DATA_W-1:0]   r_q;
  logic [DATA_W-1:0]   r_r;

  logic                w_any;
  logic [ID_W-1:0]     w_gnt;
  logic [DATA_W-1:0]   w_sel_dvd;
  logic [DATA_W-1:0]   w_sel_dvs;
  logic [N_REQ-1:0]    w_own;
  logic                w_neg_dvd;
  logic                w_neg_dvs;
  logic [DATA_W-1:0]   w_mag_dvd;
  logic [DATA_W-1:0]   w_mag_dvs;
  logic [DATA_W-1:0]   w_q_fix;
  logic [DATA_W-1:0]   w_r_fix;
  logic                w_core_start;
  logic                w_core_done;
  logic [DATA_W-1:0]   w_core_q;
  logic [DATA_W-1:0]   w_core_r;

  // Round-robin pick: scan downward so the nearest requester above r_last wins
  always_comb begin
    int idx;
    logic [ID_W-1:0] w_cand;
    w_any  = 1'b0;
    w_gnt  = '0;
    idx    = 0;
    w_cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx    = (int'(r_last) + k) % N_REQ;
      w_cand = ID_W'(idx);
      if (req_valid[w_cand]) begin
        w_any = 1'b1;
        w_gnt = w_cand;
      end
    end
  end

  // Winner's operands, one-hot accept (IDLE only) and owner one-hot
  always_comb begin
    w_sel_dvd = req_dividend[int'(w_gnt)*DATA_W +: DATA_W];
    w_sel_dvs = req_divisor[int'(w_gnt)*DATA_W +: DATA_W];
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (r_state == S_IDLE) && w_any && (w_gnt == ID_W'(i));
      w_own[i]     = (r_gid == ID_W'(i));
    end
  end

  // Sign/magnitude conversion into the core and sign correction out of it
  always_comb begin
    w_neg_dvd = r_sgn & r_dvd[DATA_W-1];
    w_neg_dvs = r_sgn & r_dvs[DATA_W-1];
    w_mag_dvd = w_neg_dvd ? (~r_dvd + 1'b1) : r_dvd;
    w_mag_dvs = w_neg_dvs ? (~r_dvs + 1'b1) : r_dvs;
    w_q_fix   = (w_neg_dvd ^ w_neg_dvs) ? (~w_core_q + 1'b1) : w_core_q;
    w_r_fix   = w_neg_dvd ? (~w_core_r + 1'b1) : w_core_r;
  end

  assign w_core_start = (r_state == S_START);

  div_subshift #(.W(DATA_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (w_core_start),
    .dividend  (w_mag_dvd),
    .divisor   (w_mag_dvs),
    .done      (w_core_done),
    .quotient  (w_core_q),
    .remainder (w_core_r)
  );

  // Control FSM: accept, start core, wait for done low-then-high, respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= ID_W'(N_REQ - 1);
      r_gid       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_sgn       <= 1'b0;
      r_seen_low  <= 1'b0;
      r_rsp_valid <= '0;
      r_q         <= '0;
      r_r         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gid      <= w_gnt;
            r_last     <= w_gnt;
            r_dvd      <= w_sel_dvd;
            r_dvs      <= w_sel_dvs;
            r_sgn      <= req_signed[w_gnt];
            r_seen_low <= 1'b0;
            if (w_sel_dvs == '0) begin
              // Divide by zero bypasses the core entirely
              r_q         <= '1;
              r_r         <= w_sel_dvd;
              r_rsp_valid <= req_ready;
              r_state     <= S_RESP;
            end else begin
              r_state <= S_START;
            end
          end
        end
        S_START: r_state <= S_RUN;
        S_RUN: begin
          if (!w_core_done) begin
            r_seen_low <= 1'b1;
          end else if (r_seen_low) begin
            r_q         <= w_q_fix;
            r_r         <= w_r_fix;
            r_rsp_valid <= w_own;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready[r_gid]) begin
            r_rsp_valid <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid     = r_rsp_valid;
  assign rsp_quotient  = r_q;
  assign rsp_remainder = r_r;
  assign busy          = (r_state != S_IDLE);
  assign grant_id      = r_gid;
  assign dbg_state     = r_state;
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shares one `div_subshift` sequential divider among `N_REQ` requesters. Arbitration is round-robin with one division in flight at a time. The block adds signed-operand support by sign/magnitude pre- and post-processing, and it short-circuits division by zero without using the core. It sits between the requesting units (CPU or accelerator ports) and the single divider instance it owns internally.

## Interface
- `DATA_W`, 32: operand/result width.
- `N_REQ`, 4: number of requesters (≥2).
- `ID_W`, `$clog2(N_REQ)`: width of the grant index.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request.
- `req_ready`  out  N_REQ  one-hot accept, only in IDLE.
- `req_signed`  in  N_REQ  1 = two's-complement operands.
- `req_dividend`  in  N_REQ*DATA_W  flattened; requester i at `[i*DATA_W +: DATA_W]`.
- `req_divisor`  in  N_REQ*DATA_W  same packing.
- `rsp_valid`  out  N_REQ  one-hot; result belongs to the set bit.
- `rsp_ready`  in  N_REQ  per-requester result accept.
- `rsp_quotient`  out  DATA_W  shared result bus.
- `rsp_remainder`  out  DATA_W  shared result bus.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  ID_W  index of the requester currently owned.

## Operation
- FSM states: IDLE, START, RUN, RESP.
- IDLE:
  - If any `req_valid` is high, pick winner g round-robin, searching upward from `last+1` mod N_REQ.
  - `last` resets to N_REQ-1, so requester 0 wins first.
  - Drive `req_ready[g]`=1 combinationally in the same cycle. Latch operands, sign flag and g; set `last`=g.
  - Next state: RESP if divisor==0, else START.
- START: assert core `start` for exactly one cycle, with magnitudes as operands.
  - Unsigned requests: magnitude = operand.
  - Signed requests: magnitude = negated operand if MSB=1. |−2^(DATA_W−1)| = 2^(DATA_W−1) is representable unsigned.
- RUN: wait until core `done` has been seen low and then returns high. On that cycle, register the sign-corrected results and go to RESP.
  - Quotient is negated if signed and dividend/divisor signs differ.
  - Remainder is negated if signed and dividend negative, so its sign follows the dividend.
- RESP: `rsp_valid[g]`=1. Hold `rsp_*`, `grant_id` and `rsp_valid` stable until `rsp_ready[g]`; then go to IDLE. `rsp_ready` of other requesters is ignored.
- Divide by zero, signed or unsigned: quotient = all ones, remainder = dividend unchanged.
- −2^(DATA_W−1) / −1 (signed): quotient = −2^(DATA_W−1), remainder = 0. This falls out of the magnitude path; no special case.
- No request is accepted in START/RUN/RESP; `req_ready`=0 there. Requesters must hold `req_valid` and operands until accepted.
- `rst` asserted in any state:
  - FSM returns to IDLE and `last` to N_REQ−1.
  - The in-flight request is dropped with no response.
  - The internal core is reset by the same `rst`.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_quotient`=0, `rsp_remainder`=0, `busy`=0, `grant_id`=0.
- Accept cycle A is the cycle with `req_valid[g]&req_ready[g]`.
- START is at A+1. Core `done` is low A+2..A+DATA_W+1 and high again at A+DATA_W+2.
- First `rsp_valid` cycle:
  - Normal divide: A+DATA_W+3 (DATA_W=8: A+11).
  - Divide by zero: A+1.
- Response handshake at cycle R: IDLE at R+1; the next accept is possible at R+1.
- Minimum initiation interval: DATA_W+4 cycles for a normal divide, 2 cycles for divide by zero.
- A `req_valid` deasserted before acceptance is legal and simply not granted. Arbitration uses only current-cycle `req_valid`.

## Test plan
All scenarios use DATA_W=8, N_REQ=4.
- Req 0, unsigned 100/7 -> q=14, r=2; `rsp_valid[0]` first high at A+11; `busy` high A+1..response cycle.
- Req 1, signed −100/7 -> q=0xF2, r=0xFE. Signed 100/−7 -> q=0xF2, r=0x02. Signed −100/−7 -> q=0x0E, r=0xFE.
- Signed 0x80/0xFF -> q=0x80, r=0. Unsigned 0xFF/0x01 -> q=0xFF, r=0. Unsigned 0x05/0x09 -> q=0, r=5.
- Unsigned 0x5A/0 -> q=0xFF, r=0x5A, `rsp_valid` at A+1. Signed 0xA6/0 -> q=0xFF, r=0xA6.
- All four `req_valid` held high:
  - Grant order is 0,1,2,3,0 and `grant_id` matches each.
  - Holding `rsp_ready` low 5 cycles in RESP keeps outputs stable and `req_ready` all 0.
- `rst` pulsed at A+5 of a divide:
  - All outputs 0 next cycle; no response is issued for the dropped request.
  - After release, a request from req 2 with only req 2 valid is served normally with correct result and latency.
